uart_guess_ctrl: RTL and testbench

Controller that sequences the UART receive path and hands validated letter guesses to the game FSM.
- Gates the receiver via rec_ready.
- Screens received bytes for ASCII letters and upper-cases them.
- Presents each guess with a valid/ack handshake and an ack timeout.
- Owns error-LED timing and a saturating error counter.
- Sits between the UART receiver/buffer path and the game logic.

---
 rtl/uart_guess_ctrl.sv | 138 +++++++++++++
 tb/tb_uart_guess_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_guess_ctrl.sv
// Receive-path sequencer: arms the UART receiver, screens bytes for ASCII letters,
// presents upper-cased guesses with a valid/ack handshake, and tracks receive errors.
module uart_guess_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 1000,
  parameter int unsigned ERR_HOLD    = 5000000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       en,
  input  logic       rx_ready,
  input  logic [7:0] rx_byte,
  input  logic       rx_err,
  input  logic       guess_ack,
  input  logic       clr_err,
  output logic       rec_ready,
  output logic       guess_valid,
  output logic [7:0] guess,
  output logic       bad_char,
  output logic       timeout,
  output logic       err_led,
  output logic [3:0] err_count
);

  typedef enum logic [2:0] {IDLE, ARM, CHECK, PRESENT, ERR} state_e;

  // One counter serves both the ack window and the error-LED hold.
  localparam int unsigned HOLD_W = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;
  localparam int unsigned CNT_W  = (HOLD_W > 16) ? HOLD_W : 16;
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ERR_HOLD - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       byte_q;
  logic [7:0]       guess_q;
  logic [3:0]       err_count_q;
  logic             rec_ready_q, guess_valid_q, bad_char_q, timeout_q, err_led_q;

  logic is_lower, is_upper;
  assign is_lower = (byte_q >= 8'h61) && (byte_q <= 8'h7A);
  assign is_upper = (byte_q >= 8'h41) && (byte_q <= 8'h5A);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      byte_q        <= '0;
      guess_q       <= '0;
      err_count_q   <= '0;
      rec_ready_q   <= 1'b0;
      guess_valid_q <= 1'b0;
      bad_char_q    <= 1'b0;
      timeout_q     <= 1'b0;
      err_led_q     <= 1'b0;
    end else begin
      bad_char_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q     <= ARM;
            rec_ready_q <= 1'b1;
          end
        end
        ARM: begin
          if (rx_err) begin
            state_q     <= ERR;
            rec_ready_q <= 1'b0;
            err_led_q   <= 1'b1;
            cnt_q       <= '0;
            err_count_q <= sat_inc(err_count_q);
          end else if (rx_ready) begin
            byte_q      <= rx_byte;
            state_q     <= CHECK;
            rec_ready_q <= 1'b0;
          end else if (!en) begin
            state_q     <= IDLE;
            rec_ready_q <= 1'b0;
          end
        end
        CHECK: begin
          if (is_lower || is_upper) begin
            guess_q       <= is_lower ? (byte_q - 8'h20) : byte_q;
            guess_valid_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= PRESENT;
          end else begin
            bad_char_q  <= 1'b1;
            err_count_q <= sat_inc(err_count_q);
            state_q     <= en ? ARM : IDLE;
            rec_ready_q <= en;
          end
        end
        PRESENT: begin
          // Ack beats both abort and expiry; abort beats expiry (no timeout pulse).
          if (guess_ack) begin
            guess_valid_q <= 1'b0;
            state_q       <= en ? ARM : IDLE;
            rec_ready_q   <= en;
          end else if (!en) begin
            guess_valid_q <= 1'b0;
            state_q       <= IDLE;
          end else if (cnt_q == ACK_LAST) begin
            guess_valid_q <= 1'b0;
            timeout_q     <= 1'b1;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ERR: begin
          if (cnt_q == HOLD_LAST) begin
            err_led_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      // NOTE: the later nonblocking assignment wins, so clr_err overrides a same-cycle increment.
      if (clr_err) err_count_q <= '0;
    end
  end

  assign rec_ready   = rec_ready_q;
  assign guess_valid = guess_valid_q;
  assign guess       = guess_q;
  assign bad_char    = bad_char_q;
  assign timeout     = timeout_q;
  assign err_led     = err_led_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_guess_ctrl.sv
// Directed bench for uart_guess_ctrl with ACK_TIMEOUT=8, ERR_HOLD=4; expected values hand-derived.
module tb_uart_guess_ctrl;

  logic       clk = 1'b0;
  logic       nRst;
  logic       en, rx_ready, rx_err, guess_ack, clr_err;
  logic [7:0] rx_byte;
  logic       rec_ready, guess_valid, bad_char, timeout, err_led;
  logic [7:0] guess;
  logic [3:0] err_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_guess_ctrl #(.ACK_TIMEOUT(8), .ERR_HOLD(4)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .en         (en),
    .rx_ready   (rx_ready),
    .rx_byte    (rx_byte),
    .rx_err     (rx_err),
    .guess_ack  (guess_ack),
    .clr_err    (clr_err),
    .rec_ready  (rec_ready),
    .guess_valid(guess_valid),
    .guess      (guess),
    .bad_char   (bad_char),
    .timeout    (timeout),
    .err_led    (err_led),
    .err_count  (err_count)
  );

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRst = 1'b0; en = 1'b0; rx_ready = 1'b0; rx_err = 1'b0;
    guess_ack = 1'b0; clr_err = 1'b0; rx_byte = 8'h00;
    tick(2);
    check("rst_rec_ready", rec_ready, 0);
    check("rst_guess_valid", guess_valid, 0);
    check("rst_guess", guess, 8'h00);
    check("rst_err_count", err_count, 0);
    check("rst_err_led", err_led, 0);
    nRst = 1'b1;

    // IDLE holds with en=0, then arms
    tick();
    check("idle_rec_ready", rec_ready, 0);
    en = 1'b1;
    tick();
    check("arm_rec_ready", rec_ready, 1);

    // lowercase 'c' -> 'C', valid two cycles after rx_ready
    rx_ready = 1'b1; rx_byte = 8'h63;
    tick();
    rx_ready = 1'b0;
    check("check_rec_ready", rec_ready, 0);
    check("check_valid_low", guess_valid, 0);
    tick();
    check("lower_valid", guess_valid, 1);
    check("lower_guess", guess, 8'h43);
    tick();
    check("present_hold", guess_valid, 1);
    guess_ack = 1'b1;
    tick();
    guess_ack = 1'b0;
    check("ack_valid_drop", guess_valid, 0);
    check("ack_rearm", rec_ready, 1);
    check("ack_no_timeout", timeout, 0);
    check("guess_kept", guess, 8'h43);

    // non-letter '7' -> bad_char pulse
    rx_ready = 1'b1; rx_byte = 8'h37;
    tick();
    rx_ready = 1'b0;
    tick();
    check("bad7_pulse", bad_char, 1);
    check("bad7_count", err_count, 1);
    check("bad7_valid", guess_valid, 0);
    check("bad7_rearm", rec_ready, 1);
    tick();
    check("bad7_pulse_end", bad_char, 0);

    // '@' sits just below 'A' and must be rejected
    rx_ready = 1'b1; rx_byte = 8'h40;
    tick();
    rx_ready = 1'b0;
    tick();
    check("bad40_pulse", bad_char, 1);
    check("bad40_count", err_count, 2);

    // 'Z' with no ack: 8 PRESENT cycles, then timeout
    rx_ready = 1'b1; rx_byte = 8'h5A;
    tick(2);
    rx_ready = 1'b0;
    check("upper_valid", guess_valid, 1);
    check("upper_guess", guess, 8'h5A);
    tick(7);
    check("to_still_valid", guess_valid, 1);
    check("to_not_yet", timeout, 0);
    tick();
    check("to_pulse", timeout, 1);
    check("to_valid_drop", guess_valid, 0);
    check("to_idle", rec_ready, 0);
    check("to_guess_kept", guess, 8'h5A);
    tick();
    check("to_pulse_end", timeout, 0);
    check("to_rearm", rec_ready, 1);

    // rx_err with simultaneous rx_ready: error wins, LED for 4 cycles
    rx_err = 1'b1; rx_ready = 1'b1; rx_byte = 8'h41;
    tick();
    rx_err = 1'b0; rx_ready = 1'b1; rx_byte = 8'h42;
    check("err_led_on", err_led, 1);
    check("err_count3", err_count, 3);
    check("err_rec_ready", rec_ready, 0);
    tick();
    rx_ready = 1'b0;
    check("err_led_c2", err_led, 1);
    tick();
    check("err_led_c3", err_led, 1);
    tick();
    check("err_led_c4", err_led, 1);
    tick();
    check("err_led_off", err_led, 0);
    check("err_no_capture_cnt", err_count, 3);
    check("err_no_valid", guess_valid, 0);
    check("err_guess_kept", guess, 8'h5A);
    tick();
    check("err_rearm", rec_ready, 1);
    check("err_no_check", guess_valid, 0);

    // 16 more rx_err events saturate the counter
    for (int k = 0; k < 16; k++) begin
      rx_err = 1'b1;
      tick();
      rx_err = 1'b0;
      tick(5);
    end
    check("sat_count", err_count, 4'hF);
    check("sat_rearm", rec_ready, 1);

    // clr_err wins over a same-cycle bad_char increment
    rx_ready = 1'b1; rx_byte = 8'h20;
    tick();
    rx_ready = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_bad_pulse", bad_char, 1);
    check("clr_count", err_count, 0);
    rx_ready = 1'b1; rx_byte = 8'h7B;
    tick(2);
    rx_ready = 1'b0;
    check("bad7b_count", err_count, 1);

    // deassert en during PRESENT: abort without timeout
    rx_ready = 1'b1; rx_byte = 8'h71;
    tick(2);
    rx_ready = 1'b0;
    check("q_guess", guess, 8'h51);
    check("q_valid", guess_valid, 1);
    en = 1'b0;
    tick();
    check("abort_valid", guess_valid, 0);
    check("abort_rec_ready", rec_ready, 0);
    for (int k = 0; k < 9; k++) begin
      check("abort_no_timeout", timeout, 0);
      tick();
    end

    // async reset mid-PRESENT
    en = 1'b1;
    tick();
    rx_ready = 1'b1; rx_byte = 8'h62;
    tick(2);
    rx_ready = 1'b0;
    check("b_valid", guess_valid, 1);
    check("b_guess", guess, 8'h42);
    #2 nRst = 1'b0;
    #1;
    check("mid_rst_valid", guess_valid, 0);
    check("mid_rst_guess", guess, 8'h00);
    check("mid_rst_count", err_count, 0);
    check("mid_rst_rec_ready", rec_ready, 0);
    check("mid_rst_timeout", timeout, 0);
    tick();
    nRst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
